// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Desc     : Shared types and constants for the PS/2 key receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT    = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK    = 8'hF0;
   localparam int         PS2_ENTRY_W       = 10;
   localparam int         PS2_ENTRY_EXT_BIT = 9;
   localparam int         PS2_ENTRY_BRK_BIT = 8;

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Desc     : 2-FF synchroniser followed by a saturating agreement filter.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_filt
);

   localparam int CW = $clog2(FILTER_LEN);

   logic [1:0]    r_sync;
   logic          r_filt;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= 2'b11;
         r_filt <= 1'b1;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[0], i_line};
         // Any sample agreeing with the current output restarts the run.
         if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_receiver
// Desc     : PS/2 keyboard deframer with prefix folding and a key FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int FIFO_DEPTH     = 8,
   parameter int DECODE_PREFIX  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          PS2Clk,
   input  logic                          PS2Data,
   output logic [7:0]                    key_code,
   output logic                          key_ext,
   output logic                          key_break,
   output logic                          key_valid,
   input  logic                          key_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam bit C_DECODE = (DECODE_PREFIX != 0);

   logic w_clk_f, w_data_f, w_fall;
   logic r_clk_prev;

   ps2_state_t r_state, w_state_nxt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic          r_par;
   logic [TW-1:0] r_tmo;
   logic          w_tmo_hit, w_err, w_byte_ok;
   logic          r_frame_err, r_byte_valid;
   logic [7:0]    r_byte;

   logic r_pend_ext, r_pend_brk;
   logic w_is_ext, w_is_brk, w_push, w_full, w_wr_en, w_pop;
   logic [PS2_ENTRY_W-1:0] w_entry;
   logic [PS2_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr, r_rd;
   logic [AW:0]            r_level;
   logic                   r_overflow;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_clk (
      .clk(clk), .reset(reset), .i_line(PS2Clk), .o_filt(w_clk_f)
   );
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_data (
      .clk(clk), .reset(reset), .i_line(PS2Data), .o_filt(w_data_f)
   );

   assign w_fall    = r_clk_prev & ~w_clk_f;
   assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES));

   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_byte_ok   = 1'b0;
      if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_data_f) w_state_nxt = ST_DATA;
               else           w_err       = 1'b1;
            end
            ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
            ST_PARITY: w_state_nxt = ST_STOP;
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (w_data_f && (^{r_shift, r_par})) w_byte_ok = 1'b1;
               else                                 w_err     = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end else if (w_tmo_hit) begin
         w_state_nxt = ST_IDLE;
         w_err       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_clk_prev   <= 1'b1;
         r_shift      <= '0;
         r_bitcnt     <= '0;
         r_par        <= 1'b0;
         r_tmo        <= '0;
         r_frame_err  <= 1'b0;
         r_byte_valid <= 1'b0;
         r_byte       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_clk_prev   <= w_clk_f;
         r_frame_err  <= w_err;
         r_byte_valid <= w_byte_ok;
         if (w_byte_ok) r_byte <= r_shift;
         if (r_state == ST_IDLE || w_fall || w_tmo_hit) r_tmo <= '0;
         else                                           r_tmo <= r_tmo + TW'(1);
         if (w_fall) begin
            case (r_state)
               ST_IDLE:   r_bitcnt <= '0;
               ST_DATA: begin
                  r_shift  <= {w_data_f, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               ST_PARITY: r_par <= w_data_f;
               default:   r_par <= r_par;
            endcase
         end
      end
   end

   // Prefix bytes only update the pending flags; they never reach the FIFO.
   assign w_is_ext = C_DECODE && (r_byte == PS2_PREFIX_EXT);
   assign w_is_brk = C_DECODE && (r_byte == PS2_PREFIX_BRK);
   assign w_push   = r_byte_valid && !w_is_ext && !w_is_brk;
   assign w_entry  = {r_pend_ext, r_pend_brk, r_byte};
   assign w_full   = (r_level == (AW+1)'(FIFO_DEPTH));
   assign w_wr_en  = w_push && !w_full;
   assign w_pop    = key_valid && key_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_ext <= 1'b0;
         r_pend_brk <= 1'b0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (r_frame_err) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
         end else if (r_byte_valid) begin
            if (w_is_ext)      r_pend_ext <= 1'b1;
            else if (w_is_brk) r_pend_brk <= 1'b1;
            else begin
               r_pend_ext <= 1'b0;
               r_pend_brk <= 1'b0;
            end
         end
         if (w_push && w_full) r_overflow <= 1'b1;
         if (w_wr_en) begin
            r_mem[r_wr] <= w_entry;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         case ({w_wr_en, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign key_code   = r_mem[r_rd][7:0];
   assign key_ext    = r_mem[r_rd][PS2_ENTRY_EXT_BIT];
   assign key_break  = r_mem[r_rd][PS2_ENTRY_BRK_BIT];
   assign key_valid  = (r_level != '0);
   assign fifo_level = r_level;
   assign frame_err  = r_frame_err;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire
